core161c_mem: RTL and testbench

- 16K x 36-bit core memory bank (DEC 161C-style) on the PDP-10 memory bus, with four processor ports p0..p3.
- Each port performs read, write or read-modify-write cycles using the membus request/acknowledge/restart handshake.
- Sits beside the KA10 CPU; its data output is ORed onto the shared mb bus.

---
 rtl/core161c_pkg.sv | 33 +++
 rtl/core161c_mem_if.sv | 28 ++
 rtl/core161c_port_sel.sv | 36 +++
 rtl/core161c_mem.sv | 145 ++++++++++++++
 tb/tb_core161c_mem.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/core161c_pkg.sv
// Shared constants, FSM state encoding and the port priority encoder
// for the 161C-style 16K x 36 core memory bank.
package core161c_pkg;

    localparam int WORD_W    = 36;
    localparam int ADDR_W    = 14;
    localparam int MEM_WORDS = 16384;
    localparam int MA_W      = 15;
    localparam int SEL_W     = 4;
    localparam int NPORTS    = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RD1,
        RDRS,
        WAITWR,
        WR1,
        RESTORE,
        HALT
    } state_t;

    typedef logic [1:0] port_idx_t;

    // Lowest-numbered set bit wins.
    function automatic port_idx_t prio_enc(input logic [NPORTS-1:0] v);
        prio_enc = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = port_idx_t'(i);
        end
    endfunction

endpackage

// File: rtl/core161c_mem_if.sv
// One PDP-10 memory-bus processor port as seen by a core bank.
// ma[13:0] is the word address (bus bits 22:35); ma[14] is bus bit 21.
interface core161c_mem_if;
    import core161c_pkg::*;

    logic              rq_cyc;
    logic              rd_rq;
    logic              wr_rq;
    logic              wr_rs;
    logic [MA_W-1:0]   ma;
    logic [SEL_W-1:0]  sel;
    logic              fmc_select;
    logic [WORD_W-1:0] mb_in;
    logic              addr_ack;
    logic              rd_rs;
    logic [WORD_W-1:0] mb_out;

    modport master (
        output rq_cyc, rd_rq, wr_rq, wr_rs, ma, sel, fmc_select, mb_in,
        input  addr_ack, rd_rs, mb_out
    );

    modport slave (
        input  rq_cyc, rd_rq, wr_rq, wr_rs, ma, sel, fmc_select, mb_in,
        output addr_ack, rd_rs, mb_out
    );

endinterface

// File: rtl/core161c_port_sel.sv
// Port qualification, per-port "served" flags and fixed-priority grant.
// A port is served once per rq_cyc assertion: the flag sets on its ack
// and clears when rq_cyc drops.
module core161c_port_sel
    import core161c_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              power,
    input  logic [NPORTS-1:0] rq_cyc,
    input  logic [NPORTS-1:0] sel_ok,
    input  logic [NPORTS-1:0] ack,
    output logic              any_hit,
    output port_idx_t         grant
);

    logic [NPORTS-1:0] served;
    logic [NPORTS-1:0] hit;

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served <= '0;
        end else if (!power) begin
            served <= '0;
        end else begin
            served <= (served | ack) & rq_cyc;
        end
    end

    assign hit     = {NPORTS{power}} & rq_cyc & sel_ok & ~served;
    assign any_hit = |hit;
    assign grant   = prio_enc(hit);

endmodule

// File: rtl/core161c_mem.sv
// 16K x 36 core memory bank with four memory-bus ports performing
// read, write and read-modify-write cycles, with single-step halt.
module core161c_mem
    import core161c_pkg::*;
#(
    parameter logic [SEL_W-1:0] memsel_p0 = 4'b0000,
    parameter logic [SEL_W-1:0] memsel_p1 = 4'b0000,
    parameter logic [SEL_W-1:0] memsel_p2 = 4'b0000,
    parameter logic [SEL_W-1:0] memsel_p3 = 4'b0000
)
(
    input logic           clk,
    input logic           reset,
    input logic           power,
    input logic           sw_single_step,
    input logic           sw_restart,
    core161c_mem_if.slave p0,
    core161c_mem_if.slave p1,
    core161c_mem_if.slave p2,
    core161c_mem_if.slave p3
);

    logic [WORD_W-1:0] core [MEM_WORDS];

    logic [NPORTS-1:0] rq_cyc, rd_rq, wr_rq, wr_rs, sel_ok;
    logic [NPORTS-1:0] ack_vec, rdrs_vec;
    logic [ADDR_W-1:0] ma_a    [NPORTS];
    logic [WORD_W-1:0] mb_in_a [NPORTS];

    state_t            state, state_nx;
    port_idx_t         port_q, grant;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q, restart_q;
    logic [WORD_W-1:0] rdata;
    logic              any_hit, latch, wr_en, drive;

    assign rq_cyc = {p3.rq_cyc, p2.rq_cyc, p1.rq_cyc, p0.rq_cyc};
    assign rd_rq  = {p3.rd_rq,  p2.rd_rq,  p1.rd_rq,  p0.rd_rq};
    assign wr_rq  = {p3.wr_rq,  p2.wr_rq,  p1.wr_rq,  p0.wr_rq};
    assign wr_rs  = {p3.wr_rs,  p2.wr_rs,  p1.wr_rs,  p0.wr_rs};
    assign sel_ok = {(p3.sel == memsel_p3) && !p3.fmc_select,
                     (p2.sel == memsel_p2) && !p2.fmc_select,
                     (p1.sel == memsel_p1) && !p1.fmc_select,
                     (p0.sel == memsel_p0) && !p0.fmc_select};

    assign ma_a[0] = p0.ma[ADDR_W-1:0];
    assign ma_a[1] = p1.ma[ADDR_W-1:0];
    assign ma_a[2] = p2.ma[ADDR_W-1:0];
    assign ma_a[3] = p3.ma[ADDR_W-1:0];
    assign mb_in_a[0] = p0.mb_in;
    assign mb_in_a[1] = p1.mb_in;
    assign mb_in_a[2] = p2.mb_in;
    assign mb_in_a[3] = p3.mb_in;

    // Bus bit 21 belongs to the bank select, not the word address.
    logic unused_ma_hi;
    assign unused_ma_hi = ^{p0.ma[MA_W-1], p1.ma[MA_W-1], p2.ma[MA_W-1], p3.ma[MA_W-1]};

    core161c_port_sel u_port_sel (
        .clk     (clk),
        .reset   (reset),
        .power   (power),
        .rq_cyc  (rq_cyc),
        .sel_ok  (sel_ok),
        .ack     (ack_vec),
        .any_hit (any_hit),
        .grant   (grant)
    );

    assign latch = (state == IDLE) && any_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            port_q    <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state     <= state_nx;
            restart_q <= sw_restart;
            if (latch) begin
                port_q <= grant;
                addr_q <= ma_a[grant];
                rd_q   <= rd_rq[grant];
                wr_q   <= wr_rq[grant];
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        if (!power) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:         if (any_hit) state_nx = ACK;
                ACK:          state_nx = rd_q ? RD1 : WAITWR;
                RD1:          state_nx = RDRS;
                RDRS:         state_nx = wr_q ? WAITWR : RESTORE;
                WAITWR:       if (wr_rs[port_q]) state_nx = WR1;
                WR1, RESTORE: state_nx = sw_single_step ? HALT : IDLE;
                HALT:         if (!sw_single_step || (sw_restart && !restart_q)) state_nx = IDLE;
                default:      state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        ack_vec  = '0;
        rdrs_vec = '0;
        if (power && state == ACK)  ack_vec[port_q]  = 1'b1;
        if (power && state == RDRS) rdrs_vec[port_q] = 1'b1;
    end

    // Read data stays on the bus from the restart pulse until the cycle ends.
    assign drive = power && rd_q &&
                   (state == RDRS || state == WAITWR || state == WR1 || state == RESTORE);
    assign wr_en = reset && power && (state == WAITWR) && wr_rs[port_q];

    // NOTE: the core array and its read register have no reset: contents
    // must survive reset and be preloadable, and a reset here would stop
    // the array from mapping onto RAM.
    always_ff @(posedge clk) begin
        if (state == RD1) rdata <= core[addr_q];
        if (wr_en)        core[addr_q] <= mb_in_a[port_q];
    end

    assign p0.addr_ack = ack_vec[0];
    assign p1.addr_ack = ack_vec[1];
    assign p2.addr_ack = ack_vec[2];
    assign p3.addr_ack = ack_vec[3];
    assign p0.rd_rs    = rdrs_vec[0];
    assign p1.rd_rs    = rdrs_vec[1];
    assign p2.rd_rs    = rdrs_vec[2];
    assign p3.rd_rs    = rdrs_vec[3];
    assign p0.mb_out   = (drive && port_q == 2'd0) ? rdata : '0;
    assign p1.mb_out   = (drive && port_q == 2'd1) ? rdata : '0;
    assign p2.mb_out   = (drive && port_q == 2'd2) ? rdata : '0;
    assign p3.mb_out   = (drive && port_q == 2'd3) ? rdata : '0;

endmodule

// File: tb/tb_core161c_mem.sv
// Scoreboard bench for core161c_mem: stimulus queues the expected
// addr_ack / rd_rs events, a negedge monitor pops and compares them.
module tb_core161c_mem;
    import core161c_pkg::*;

    localparam int EV_ACK  = 0;
    localparam int EV_RDRS = 1;
    localparam logic [35:0] D20  = 36'o254000000100;
    localparam logic [35:0] DWR  = 36'o123456111222;
    localparam logic [35:0] D300 = 36'o777;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic power = 1'b0;
    logic ss = 1'b0;
    logic restart = 1'b0;

    core161c_mem_if bus0 ();
    core161c_mem_if bus1 ();
    core161c_mem_if bus2 ();
    core161c_mem_if bus3 ();

    core161c_mem dut (
        .clk            (clk),
        .reset          (reset),
        .power          (power),
        .sw_single_step (ss),
        .sw_restart     (restart),
        .p0             (bus0),
        .p1             (bus1),
        .p2             (bus2),
        .p3             (bus3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        int          kind;
        int          port;
        logic [35:0] data;
        int          at;
    } ev_t;
    ev_t sb[$];

    logic [3:0]  acks, rdrs;
    logic [35:0] mbo [4];
    assign acks   = {bus3.addr_ack, bus2.addr_ack, bus1.addr_ack, bus0.addr_ack};
    assign rdrs   = {bus3.rd_rs, bus2.rd_rs, bus1.rd_rs, bus0.rd_rs};
    assign mbo[0] = bus0.mb_out;
    assign mbo[1] = bus1.mb_out;
    assign mbo[2] = bus2.mb_out;
    assign mbo[3] = bus3.mb_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0o expected=%0o t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int port, input logic [35:0] data, input int at);
        sb.push_back(ev_t'{kind, port, data, at});
    endtask

    task automatic wait_out(input int p, input int kind, input int budget, input string name);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (kind == EV_ACK ? acks[p] : rdrs[p]) found = 1'b1;
        end
        check(name, 64'(found), 64'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req0(input logic [14:0] ma, input logic rd, input logic wr);
        bus0.ma     = ma;
        bus0.rd_rq  = rd;
        bus0.wr_rq  = wr;
        bus0.rq_cyc = 1'b1;
    endtask

    // Monitor: every strobe the DUT raises must match the head of the queue.
    always @(negedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (acks[p] || rdrs[p]) begin
                ev_t e;
                int  k;
                k = rdrs[p] ? EV_RDRS : EV_ACK;
                check("event_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("event_kind_port", 64'(k * 4 + p), 64'(e.kind * 4 + e.port));
                    if (e.at >= 0) check("event_cycle", 64'(cyc), 64'(e.at));
                    if (k == EV_RDRS) check("read_data", 64'(mbo[p]), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int c;

        bus0.rq_cyc = 0; bus0.rd_rq = 0; bus0.wr_rq = 0; bus0.wr_rs = 0;
        bus0.ma = 0; bus0.sel = 0; bus0.fmc_select = 0; bus0.mb_in = 0;
        bus1.rq_cyc = 0; bus1.rd_rq = 0; bus1.wr_rq = 0; bus1.wr_rs = 0;
        bus1.ma = 0; bus1.sel = 0; bus1.fmc_select = 0; bus1.mb_in = 0;
        bus2.rq_cyc = 0; bus2.rd_rq = 0; bus2.wr_rq = 0; bus2.wr_rs = 0;
        bus2.ma = 0; bus2.sel = 0; bus2.fmc_select = 0; bus2.mb_in = 0;
        bus3.rq_cyc = 0; bus3.rd_rq = 0; bus3.wr_rq = 0; bus3.wr_rs = 0;
        bus3.ma = 0; bus3.sel = 0; bus3.fmc_select = 0; bus3.mb_in = 0;

        dut.core[14'o20]  = D20;
        dut.core[14'o141] = 36'd1;
        dut.core[14'o200] = 36'd0;
        dut.core[14'o300] = D300;

        power = 1'b1;
        idle(3);
        check("reset_addr_ack", 64'(bus0.addr_ack), 64'd0);
        check("reset_rd_rs", 64'(bus0.rd_rs), 64'd0);
        check("reset_mb_out", 64'(bus0.mb_out), 64'd0);
        check("reset_state", 64'(dut.state), 64'(IDLE));
        reset = 1'b1;
        idle(2);

        // Plain read of a preloaded word.
        req0(15'o20, 1'b1, 1'b0);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        expect_ev(EV_RDRS, 0, D20, cyc + 3);
        wait_out(0, EV_RDRS, 10, "wait_read_rdrs");
        bus0.rq_cyc = 0; bus0.rd_rq = 0;
        idle(4);
        check("read_core_unchanged", 64'(dut.core[14'o20]), 64'(D20));

        // Write-only cycle.
        req0(15'o200, 1'b0, 1'b1);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        wait_out(0, EV_ACK, 10, "wait_write_ack");
        @(negedge clk);
        check("write_in_waitwr", 64'(dut.state), 64'(WAITWR));
        bus0.mb_in = DWR; bus0.wr_rs = 1;
        @(negedge clk);
        bus0.wr_rs = 0; bus0.rq_cyc = 0; bus0.wr_rq = 0; bus0.mb_in = 0;
        idle(4);
        check("write_core", 64'(dut.core[14'o200]), 64'(DWR));

        // Read-modify-write.
        req0(15'o141, 1'b1, 1'b1);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        expect_ev(EV_RDRS, 0, 36'd1, cyc + 3);
        wait_out(0, EV_RDRS, 10, "wait_rmw_rdrs");
        idle(5);
        check("rmw_waits", 64'(dut.state), 64'(WAITWR));
        check("rmw_data_held", 64'(bus0.mb_out), 64'd1);
        bus0.mb_in = 36'd2; bus0.wr_rs = 1;
        @(negedge clk);
        bus0.wr_rs = 0; bus0.rq_cyc = 0; bus0.rd_rq = 0; bus0.wr_rq = 0; bus0.mb_in = 0;
        idle(3);
        check("rmw_core", 64'(dut.core[14'o141]), 64'd2);
        check("rmw_mb_out_released", 64'(bus0.mb_out), 64'd0);

        // Bank select mismatch, then fast-memory access: both ignored.
        bus0.sel = 4'b0001;
        req0(15'o20, 1'b1, 1'b0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.addr_ack || bus0.mb_out != 0) seen++;
        end
        check("sel_mismatch_ignored", 64'(seen), 64'd0);
        bus0.sel = 4'b0000; bus0.fmc_select = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus0.addr_ack || bus0.mb_out != 0) seen++;
        end
        check("fmc_ignored", 64'(seen), 64'd0);
        bus0.rq_cyc = 0; bus0.fmc_select = 0; bus0.rd_rq = 0;
        idle(2);

        // p0 and p1 together: p0 first, p0 not re-served, then p1.
        c = cyc;
        req0(15'o20, 1'b1, 1'b0);
        bus1.ma = 15'o141; bus1.rd_rq = 1; bus1.rq_cyc = 1;
        expect_ev(EV_ACK, 0, 36'd0, c + 1);
        expect_ev(EV_RDRS, 0, D20, c + 3);
        expect_ev(EV_ACK, 1, 36'd0, c + 6);
        expect_ev(EV_RDRS, 1, 36'd2, c + 8);
        wait_out(1, EV_RDRS, 30, "wait_p1_rdrs");
        idle(12);
        check("arb_no_reservice", 64'(sb.size()), 64'd0);
        bus0.rq_cyc = 0; bus0.rd_rq = 0;
        bus1.rq_cyc = 0; bus1.rd_rq = 0;
        idle(3);

        // Power drop while waiting for write data.
        req0(15'o300, 1'b1, 1'b1);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        expect_ev(EV_RDRS, 0, D300, cyc + 3);
        wait_out(0, EV_RDRS, 10, "wait_pwr_rdrs");
        @(negedge clk);
        check("pwr_data_before_drop", 64'(bus0.mb_out), 64'(D300));
        power = 0; bus0.wr_rs = 1; bus0.mb_in = 36'd5;
        #1;
        check("pwr_mb_out_zero", 64'(bus0.mb_out), 64'd0);
        @(negedge clk);
        check("pwr_state_idle", 64'(dut.state), 64'(IDLE));
        bus0.wr_rs = 0; bus0.rq_cyc = 0; bus0.rd_rq = 0; bus0.wr_rq = 0; bus0.mb_in = 0;
        power = 1;
        idle(3);
        check("pwr_no_write", 64'(dut.core[14'o300]), 64'(D300));

        // Reset pulse while waiting for write data.
        req0(15'o20, 1'b1, 1'b1);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        expect_ev(EV_RDRS, 0, D20, cyc + 3);
        wait_out(0, EV_RDRS, 10, "wait_rst_rdrs");
        @(negedge clk);
        reset = 0; bus0.rq_cyc = 0; bus0.wr_rs = 1; bus0.mb_in = 36'd7;
        #1;
        check("rst_mb_out_zero", 64'(bus0.mb_out), 64'd0);
        check("rst_state_idle", 64'(dut.state), 64'(IDLE));
        @(negedge clk);
        bus0.wr_rs = 0; bus0.rd_rq = 0; bus0.wr_rq = 0; bus0.mb_in = 0;
        reset = 1;
        idle(3);
        check("rst_no_write", 64'(dut.core[14'o20]), 64'(D20));

        // Normal read after the aborts.
        req0(15'o141, 1'b1, 1'b0);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        expect_ev(EV_RDRS, 0, 36'd2, cyc + 3);
        wait_out(0, EV_RDRS, 10, "wait_recover_rdrs");
        bus0.rq_cyc = 0; bus0.rd_rq = 0;
        idle(4);

        // Single step: halt after the cycle, released by a restart edge.
        ss = 1;
        req0(15'o20, 1'b1, 1'b0);
        expect_ev(EV_ACK, 0, 36'd0, cyc + 1);
        expect_ev(EV_RDRS, 0, D20, cyc + 3);
        wait_out(0, EV_RDRS, 10, "wait_step_rdrs");
        bus0.rq_cyc = 0; bus0.rd_rq = 0;
        idle(2);
        check("step_halted", 64'(dut.state), 64'(HALT));
        idle(3);
        check("step_holds", 64'(dut.state), 64'(HALT));
        restart = 1;
        @(negedge clk);
        check("step_released", 64'(dut.state), 64'(IDLE));
        restart = 0; ss = 0;
        idle(2);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
